// File: rtl/memory_v3_pkg.sv
// memory_v3_pkg: shared constants, region type and helpers for memory_v3.
//   - IO window offsets (relative to IO_BASE = 2**ADDR_WIDTH - 16)
//   - error flag bit positions and the mask of implemented flags
//   - region_t: decoded target of a word address
package memory_v3_pkg;

  localparam int unsigned IO_WINDOW = 16;
  localparam int unsigned OUT_OFS   = 0;
  localparam int unsigned IN_OFS    = 8;
  localparam int unsigned BTN_OFS   = 14;
  localparam int unsigned ERR_OFS   = 15;

  localparam int unsigned ERR_RO_WRITE    = 0;
  localparam int unsigned ERR_UNMAPPED    = 1;
  localparam int unsigned ERR_RW_CONFLICT = 2;
  localparam int unsigned ERR_WIDTH       = 8;

  // Only bits 2..0 exist; 7..3 must never set.
  localparam logic [ERR_WIDTH-1:0] ERR_IMPL_MASK = 8'h07;

  typedef enum logic [2:0] {
    REG_RAM      = 3'd0,
    REG_OUT      = 3'd1,
    REG_IN       = 3'd2,
    REG_BTN      = 3'd3,
    REG_ERR      = 3'd4,
    REG_UNMAPPED = 3'd5
  } region_t;

  // Next value of the sticky error flags: clear-by-write-1 first, then set,
  // so an error raised in the clearing cycle survives.
  function automatic logic [ERR_WIDTH-1:0] err_update(
    input logic [ERR_WIDTH-1:0] cur,
    input logic [ERR_WIDTH-1:0] set,
    input logic [ERR_WIDTH-1:0] clr
  );
    return ((cur & ~clr) | set) & ERR_IMPL_MASK;
  endfunction

endpackage

// File: rtl/ram_v2.sv
// ram_v2: single-port synchronous RAM with registered read.
//   clk   : rising-edge clock
//   we    : write addr with wdata at the clock edge
//   re    : capture mem[addr] into rdata at the clock edge (ignored when we=1)
//   addr  : word address, must be < DEPTH
//   wdata : write data
//   rdata : read data register; holds its value between reads
// Contents and the read register are intentionally not reset.
module ram_v2 #(
  parameter int DEPTH = 1008,
  parameter int WIDTH = 32,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Storage write and registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/memory_v3.sv
// memory_v3: memory-mapped RAM / output ports / input ports / status unit.
// Word address map, IO_BASE = 2**ADDR_WIDTH - 16:
//   < IO_BASE          RAM (read/write)
//   IO_BASE+k          output port k, k < NUM_OUT_PORTS (read/write)
//   IO_BASE+8+k        input port k, k < NUM_IN_PORTS (read-only, synchronised)
//   IO_BASE+14         button status (read-only)
//   IO_BASE+15         error status, write 1s to clear
//   other IO offsets   unmapped, read as 0
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_addr, data_in        request address and write data
//   write_enable/read_enable request strobes (write wins when both set)
//   data_out, rd_valid       read data one cycle after the read, strobe
//   in_ports, button_array   asynchronous inputs, 2-flop synchronised
//   out_ports                output-port registers, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   memory_error_vector      sticky error flags (bit0 RO write, bit1 unmapped, bit2 R+W)
// Build option: MEMORY_V3_BTN_LATCH_EN makes button status sticky on rising
// edges, cleared by reading it; otherwise the live synchronised levels are read.
module memory_v3
  import memory_v3_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_OUT_PORTS = 4,
  parameter int NUM_IN_PORTS  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ADDR_WIDTH-1:0]              mem_addr,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               write_enable,
  input  logic                               read_enable,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               rd_valid,
  input  logic [NUM_IN_PORTS*DATA_WIDTH-1:0] in_ports,
  output logic [NUM_OUT_PORTS*DATA_WIDTH-1:0] out_ports,
  input  logic [3:0]                         button_array,
  output logic [7:0]                         memory_error_vector
);

  localparam int RAM_DEPTH = (2 ** ADDR_WIDTH) - IO_WINDOW;
  localparam logic [ADDR_WIDTH-1:0] IO_BASE_ADDR = ADDR_WIDTH'(RAM_DEPTH);

  // IO_BASE is 16-word aligned, so the low nibble is the IO offset.
  logic [3:0] io_ofs_s;
  logic [2:0] port_idx_s;
  region_t    region_s;

  logic wr_s;
  logic rd_s;
  logic acc_s;

  logic [NUM_IN_PORTS*DATA_WIDTH-1:0]  in_meta_r;
  logic [NUM_IN_PORTS*DATA_WIDTH-1:0]  in_sync_r;
  logic [3:0]                          btn_meta_r;
  logic [3:0]                          btn_sync_r;
  logic [3:0]                          btn_view_s;
  logic [NUM_OUT_PORTS*DATA_WIDTH-1:0] out_r;
  logic [ERR_WIDTH-1:0]                err_r;
  logic [ERR_WIDTH-1:0]                err_set_s;
  logic [ERR_WIDTH-1:0]                err_clr_s;

  logic [DATA_WIDTH-1:0] io_rdata_s;
  logic [DATA_WIDTH-1:0] io_data_r;
  logic [DATA_WIDTH-1:0] ram_rdata_s;
  logic                  sel_ram_r;
  logic                  rd_valid_r;

  assign io_ofs_s   = mem_addr[3:0];
  // Output offsets 0..7 and input offsets 8..13 both index by the low 3 bits.
  assign port_idx_s = io_ofs_s[2:0];

  // Request qualification: a simultaneous read is dropped in favour of the write.
  assign wr_s  = write_enable & ~rst;
  assign rd_s  = read_enable & ~write_enable & ~rst;
  assign acc_s = (write_enable | read_enable) & ~rst;

  // Address decode into a target region.
  always_comb begin
    region_s = REG_UNMAPPED;
    if (mem_addr < IO_BASE_ADDR) begin
      region_s = REG_RAM;
    end else if (io_ofs_s < 4'(OUT_OFS + NUM_OUT_PORTS)) begin
      region_s = REG_OUT;
    end else if ((io_ofs_s >= 4'(IN_OFS)) && (io_ofs_s < 4'(IN_OFS + NUM_IN_PORTS))) begin
      region_s = REG_IN;
    end else if (io_ofs_s == 4'(BTN_OFS)) begin
      region_s = REG_BTN;
    end else if (io_ofs_s == 4'(ERR_OFS)) begin
      region_s = REG_ERR;
    end else begin
      region_s = REG_UNMAPPED;
    end
  end

  // Two-flop synchronisers for the asynchronous inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_meta_r  <= {(NUM_IN_PORTS*DATA_WIDTH){1'b0}};
      in_sync_r  <= {(NUM_IN_PORTS*DATA_WIDTH){1'b0}};
      btn_meta_r <= 4'h0;
      btn_sync_r <= 4'h0;
    end else begin
      in_meta_r  <= in_ports;
      in_sync_r  <= in_meta_r;
      btn_meta_r <= button_array;
      btn_sync_r <= btn_meta_r;
    end
  end

`ifdef MEMORY_V3_BTN_LATCH_EN
  logic [3:0] btn_prev_r;
  logic [3:0] btn_sticky_r;
  logic       btn_clr_s;

  assign btn_clr_s = rd_s & (region_s == REG_BTN);

  // Rising-edge capture; a clearing read still keeps an edge of the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_r   <= 4'h0;
      btn_sticky_r <= 4'h0;
    end else begin
      btn_prev_r   <= btn_sync_r;
      btn_sticky_r <= (btn_clr_s ? 4'h0 : btn_sticky_r) | (btn_sync_r & ~btn_prev_r);
    end
  end

  assign btn_view_s = btn_sticky_r;
`else
  assign btn_view_s = btn_sync_r;
`endif

  // Output-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= {(NUM_OUT_PORTS*DATA_WIDTH){1'b0}};
    end else begin
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
        if (wr_s && (region_s == REG_OUT) && (port_idx_s == 3'(k))) begin
          out_r[k*DATA_WIDTH +: DATA_WIDTH] <= data_in;
        end else begin
          out_r[k*DATA_WIDTH +: DATA_WIDTH] <= out_r[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign out_ports = out_r;

  // Error set/clear conditions for the current request.
  always_comb begin
    err_set_s = 8'h00;
    err_clr_s = 8'h00;
    err_set_s[ERR_RO_WRITE]    = wr_s & ((region_s == REG_IN) | (region_s == REG_BTN));
    err_set_s[ERR_UNMAPPED]    = acc_s & (region_s == REG_UNMAPPED);
    err_set_s[ERR_RW_CONFLICT] = write_enable & read_enable & ~rst;
    if (wr_s && (region_s == REG_ERR)) begin
      err_clr_s = data_in[ERR_WIDTH-1:0];
    end else begin
      err_clr_s = 8'h00;
    end
  end

  // Sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 8'h00;
    end else begin
      err_r <= err_update(err_r, err_set_s, err_clr_s);
    end
  end

  assign memory_error_vector = err_r;

  // IO read mux as an AND-OR of one-hot selects; unmapped offsets fall out as 0.
  always_comb begin
    io_rdata_s = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      io_rdata_s = io_rdata_s
        | ({DATA_WIDTH{(region_s == REG_OUT) && (port_idx_s == 3'(k))}}
           & out_r[k*DATA_WIDTH +: DATA_WIDTH]);
    end
    for (int k = 0; k < NUM_IN_PORTS; k++) begin
      io_rdata_s = io_rdata_s
        | ({DATA_WIDTH{(region_s == REG_IN) && (port_idx_s == 3'(k))}}
           & in_sync_r[k*DATA_WIDTH +: DATA_WIDTH]);
    end
    io_rdata_s = io_rdata_s
      | ({DATA_WIDTH{region_s == REG_BTN}} & {{(DATA_WIDTH-4){1'b0}}, btn_view_s});
    io_rdata_s = io_rdata_s
      | ({DATA_WIDTH{region_s == REG_ERR}} & {{(DATA_WIDTH-ERR_WIDTH){1'b0}}, err_r});
  end

  ram_v2 #(
    .DEPTH (RAM_DEPTH),
    .WIDTH (DATA_WIDTH),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_s & (region_s == REG_RAM)),
    .re    (rd_s & (region_s == REG_RAM)),
    .addr  (mem_addr),
    .wdata (data_in),
    .rdata (ram_rdata_s)
  );

  // Read response: valid strobe, source select and captured IO word.
  // RAM data comes from the RAM's own read register; both sources hold
  // between reads, so data_out is stable while rd_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      sel_ram_r  <= 1'b0;
      io_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (rd_s) begin
      rd_valid_r <= 1'b1;
      sel_ram_r  <= (region_s == REG_RAM);
      io_data_r  <= (region_s == REG_RAM) ? io_data_r : io_rdata_s;
    end else begin
      rd_valid_r <= 1'b0;
      sel_ram_r  <= sel_ram_r;
      io_data_r  <= io_data_r;
    end
  end

  assign rd_valid = rd_valid_r;
  assign data_out = sel_ram_r ? ram_rdata_s : io_data_r;

endmodule

// File: tb/tb_memory_v3.sv
// tb_memory_v3: directed test-plan sequences plus randomized traffic, checked
// every cycle against a behavioural model of the address map.
module tb_memory_v3;

  localparam int AW      = 10;
  localparam int DW      = 32;
  localparam int NO      = 4;
  localparam int NI      = 2;
  localparam int IO_BASE = (2 ** AW) - 16;
`ifdef MEMORY_V3_BTN_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  data_in;
  logic           write_enable;
  logic           read_enable;
  logic [DW-1:0]  data_out;
  logic           rd_valid;
  logic [NI*DW-1:0] in_ports;
  logic [NO*DW-1:0] out_ports;
  logic [3:0]     button_array;
  logic [7:0]     memory_error_vector;

  memory_v3 #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_OUT_PORTS(NO), .NUM_IN_PORTS(NI)
  ) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .data_in(data_in),
    .write_enable(write_enable), .read_enable(read_enable),
    .data_out(data_out), .rd_valid(rd_valid), .in_ports(in_ports),
    .out_ports(out_ports), .button_array(button_array),
    .memory_error_vector(memory_error_vector)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  logic [31:0]    ram_m [16];
  logic [31:0]    out_m [NO];
  logic [7:0]     err_m;
  logic [3:0]     sticky_m;
  logic [31:0]    last_m;
  logic [NI*DW-1:0] in_h [4];   // [0]=this cycle, [2]=two cycles ago
  logic [3:0]     btn_h [4];
  logic [NI*DW-1:0] in_v;
  logic [3:0]     btn_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive request, advance model, then compare after the edge.
  task automatic step(input logic r, input logic w, input logic rd,
                      input logic [AW-1:0] a, input logic [31:0] d);
    int ofs;
    bit is_ram, is_out, is_in, is_btn, is_err, unm, do_rd;
    logic [31:0] val;
    logic [7:0] set, clr;
    logic exp_valid;
    rst = r; write_enable = w; read_enable = rd; mem_addr = a; data_in = d;
    in_ports = in_v; button_array = btn_v;
    for (int i = 3; i > 0; i--) begin
      in_h[i] = in_h[i-1];
      btn_h[i] = btn_h[i-1];
    end
    in_h[0] = in_v; btn_h[0] = btn_v;
    exp_valid = 1'b0;
    if (r) begin
      for (int k = 0; k < NO; k++) out_m[k] = 32'h0;
      err_m = 8'h0; sticky_m = 4'h0; last_m = 32'h0;
      for (int i = 0; i < 4; i++) begin
        in_h[i] = '0;
        btn_h[i] = 4'h0;
      end
    end else begin
      is_ram = (int'(a) < IO_BASE);
      ofs = int'(a) - IO_BASE;
      is_out = !is_ram && ofs < NO;
      is_in  = !is_ram && ofs >= 8 && ofs < 8 + NI;
      is_btn = !is_ram && ofs == 14;
      is_err = !is_ram && ofs == 15;
      unm = !is_ram && !is_out && !is_in && !is_btn && !is_err;
      val = 32'h0;
      if (is_ram) val = ram_m[a[3:0]];
      else if (is_out) val = out_m[ofs];
      else if (is_in) val = in_h[2][(ofs-8)*DW +: DW];
      else if (is_btn) val = LATCH ? {28'h0, sticky_m} : {28'h0, btn_h[2]};
      else if (is_err) val = {24'h0, err_m};
      do_rd = rd && !w;
      set = 8'h0; clr = 8'h0;
      if (w && rd) set[2] = 1'b1;
      if ((w || rd) && unm) set[1] = 1'b1;
      if (w && (is_in || is_btn)) set[0] = 1'b1;
      if (w && is_err) clr = d[7:0];
      if (w && is_ram) ram_m[a[3:0]] = d;
      if (w && is_out) out_m[ofs] = d;
      err_m = (err_m & ~clr) | set;
      sticky_m = ((do_rd && is_btn) ? 4'h0 : sticky_m) | (btn_h[2] & ~btn_h[3]);
      if (do_rd) begin
        exp_valid = 1'b1;
        last_m = val;
      end
    end
    @(posedge clk);
    #1;
    check("rd_valid", {31'h0, rd_valid}, {31'h0, exp_valid});
    check("data_out", data_out, last_m);
    for (int k = 0; k < NO; k++) check("out_port", out_ports[k*DW +: DW], out_m[k]);
    check("err_vec", {24'h0, memory_error_vector}, {24'h0, err_m});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 32'h0);
  endtask

  initial begin
    in_v = '0; btn_v = 4'h0;
    for (int i = 0; i < 4; i++) begin
      in_h[i] = '0;
      btn_h[i] = 4'h0;
    end
    err_m = 8'h0; sticky_m = 4'h0; last_m = 32'h0;
    for (int k = 0; k < NO; k++) out_m[k] = 32'h0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, '0, 32'h0);
    step(1'b1, 1'b0, 1'b0, '0, 32'h0);
    check("reset_data_out", data_out, 32'h0);

    // Initialise the RAM words used by the random phase
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, AW'(i), $urandom);

    // RAM write then read
    step(1'b0, 1'b1, 1'b0, AW'(5), 32'hDEADBEEF);
    step(1'b0, 1'b0, 1'b1, AW'(5), 32'h0);
    check("ram_rd_valid", {31'h0, rd_valid}, 32'h1);
    check("ram_rd_data", data_out, 32'hDEADBEEF);

    // Output port write, visible next cycle, readback
    step(1'b0, 1'b1, 1'b0, AW'(IO_BASE + 2), 32'h000000A5);
    check("out2_val", out_ports[2*DW +: DW], 32'hA5);
    check("out0_val", out_ports[0 +: DW], 32'h0);
    step(1'b0, 1'b0, 1'b1, AW'(IO_BASE + 2), 32'h0);
    check("out2_readback", data_out, 32'hA5);

    // Input synchroniser latency
    in_v[DW +: DW] = 32'h1234;
    step(1'b0, 1'b0, 1'b1, AW'(IO_BASE + 9), 32'h0);
    check("in1_immediate", data_out, 32'h0);
    step(1'b0, 1'b0, 1'b1, AW'(IO_BASE + 9), 32'h0);
    check("in1_one_cycle", data_out, 32'h0);
    step(1'b0, 1'b0, 1'b1, AW'(IO_BASE + 9), 32'h0);
    check("in1_two_cycles", data_out, 32'h1234);

    // Error flags and clear
    step(1'b0, 1'b1, 1'b0, AW'(IO_BASE + 8), 32'h55);
    check("err_ro", {24'h0, memory_error_vector}, 32'h01);
    step(1'b0, 1'b0, 1'b1, AW'(IO_BASE + 12), 32'h0);
    check("err_unmapped_rd", data_out, 32'h0);
    step(1'b0, 1'b1, 1'b1, AW'(3), 32'h0BAD0003);
    check("err_all", {24'h0, memory_error_vector}, 32'h07);
    check("conflict_no_valid", {31'h0, rd_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b1, AW'(IO_BASE + 15), 32'h0);
    check("err_readback", data_out, 32'h07);
    step(1'b0, 1'b1, 1'b0, AW'(IO_BASE + 15), 32'h07);
    check("err_cleared", {24'h0, memory_error_vector}, 32'h00);

    // Button status
    btn_v = 4'h8;
    if (LATCH) begin
      idle(3);
      btn_v = 4'h0;
      idle(2);
      step(1'b0, 1'b0, 1'b1, AW'(IO_BASE + 14), 32'h0);
      check("btn_latched", data_out, 32'h8);
      step(1'b0, 1'b0, 1'b1, AW'(IO_BASE + 14), 32'h0);
      check("btn_cleared", data_out, 32'h0);
    end else begin
      idle(3);
      step(1'b0, 1'b0, 1'b1, AW'(IO_BASE + 14), 32'h0);
      check("btn_held", data_out, 32'h8);
      btn_v = 4'h0;
      idle(3);
      step(1'b0, 1'b0, 1'b1, AW'(IO_BASE + 14), 32'h0);
      check("btn_released", data_out, 32'h0);
    end

    // Reset mid-stream discards the pending read
    step(1'b0, 1'b0, 1'b1, AW'(5), 32'h0);
    step(1'b1, 1'b0, 1'b1, AW'(5), 32'h0);
    check("rst_mid_valid", {31'h0, rd_valid}, 32'h0);
    check("rst_mid_out2", out_ports[2*DW +: DW], 32'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, AW'(i), $urandom);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      int op;
      logic [AW-1:0] a;
      if ($urandom_range(0, 7) == 0) in_v = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) btn_v = 4'($urandom);
      a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15))
                                       : AW'(IO_BASE + $urandom_range(0, 15));
      op = $urandom_range(0, 9);
      if (op < 4) step(1'b0, 1'b0, 1'b1, a, 32'h0);
      else if (op < 7) step(1'b0, 1'b1, 1'b0, a, $urandom);
      else if (op == 7) step(1'b0, 1'b1, 1'b1, a, $urandom);
      else step(1'b0, 1'b0, 1'b0, a, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_v3.md
# memory_v3

Parametrised memory-mapped unit for the RISC-V core's load/store path. It decodes each word address into one of three targets:

- a synchronous RAM;
- a configurable bank of output-port registers;
- a bank of synchronised input ports plus a button/error status window.

Reads return data with a fixed one-cycle latency and a valid strobe. It replaces the fixed four-way mux organisation of the previous memory unit with a generic address decoder, sticky error reporting and button edge capture.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address width; address space is 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width
- NUM_OUT_PORTS, 4, output-port registers, 1..8
- NUM_IN_PORTS, 2, input ports, 1..6

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- mem_addr  in  ADDR_WIDTH  word address
- data_in  in  DATA_WIDTH  write data
- write_enable  in  1  write request this cycle
- read_enable  in  1  read request this cycle
- data_out  out  DATA_WIDTH  read data, valid when rd_valid
- rd_valid  out  1  one-cycle strobe, read data present
- in_ports  in  NUM_IN_PORTS*DATA_WIDTH  asynchronous external inputs, port k at [k*DATA_WIDTH +: DATA_WIDTH]
- out_ports  out  NUM_OUT_PORTS*DATA_WIDTH  output-port registers, same packing
- button_array  in  4  asynchronous push buttons
- memory_error_vector  out  8  sticky error flags

## Operation
Address map (IO_BASE = 2**ADDR_WIDTH - 16):
- Addresses below IO_BASE: RAM, read/write.
- IO_BASE+k, k<NUM_OUT_PORTS: output port k, read/write; reads return the register.
- IO_BASE+8+k, k<NUM_IN_PORTS: input port k, read-only; reads return the synchronised value.
- IO_BASE+14: button status, read-only.
- IO_BASE+15: error status. Reads return {24'b0, memory_error_vector}; writing 1s clears the corresponding bits.
- Any other I/O offset is unmapped. Reads of unmapped offsets return 0.

Request handling:
- One request is accepted per cycle; there is no back-pressure.
- write_enable and read_enable both high: the write executes, the read is dropped (rd_valid stays 0), and error bit 2 sets.

Error bits (sticky, set at the clock edge of the offending request):
- 0: write to a read-only address.
- 1: access to an unmapped I/O offset.
- 2: simultaneous read and write.
- 7..3: always 0.
- Set takes priority over a same-cycle clear.

Input synchronisation:
- in_ports and button_array each pass through a 2-flop synchroniser.

Widths:
- Ports narrower than DATA_WIDTH are zero-extended on read.

## Timing
- Reset: data_out=0, rd_valid=0, out_ports=0, memory_error_vector=0, button state=0, synchronisers=0. RAM contents are not reset.
- Read accepted in cycle N: data_out and rd_valid=1 in cycle N+1. rd_valid deasserts in N+2 unless another read is accepted in N+1.
- data_out holds its last value while rd_valid=0.
- Write in cycle N: the target updates at the end of N. A read of the same address in N+1 returns the new value. An out_ports change is visible in N+1.
- Back-to-back reads return one word per cycle.
- External input change: visible to reads issued 2 cycles later or more.
- rst asserted mid-stream: the pending read is discarded, and rd_valid=0 in the cycle after the reset edge.

## Configuration
- MEMORY_V3_BTN_LATCH_EN defined:
  - A rising edge on a synchronised button sets sticky bit [b] of button status.
  - A read of IO_BASE+14 returns the sticky bits and clears them.
  - An edge in the same cycle as the clearing read leaves that bit set.
- Not defined: IO_BASE+14 returns the live synchronised levels, with no edge detection or clearing.

## Structure
- Package memory_v3_pkg holds:
  - IO offset constants (OUT_OFS=0, IN_OFS=8, BTN_OFS=14, ERR_OFS=15);
  - error bit index constants;
  - enum region_t {REG_RAM, REG_OUT, REG_IN, REG_BTN, REG_ERR, REG_UNMAPPED}.
- Sub-module ram_v2: single-port synchronous RAM, parametrised DEPTH/WIDTH, registered read, write-enable.
- Decode, port registers, synchronisers, button logic and error logic live in the top.

## Test plan
- Reset, then write 0xDEADBEEF to RAM address 5 and read it next cycle -> rd_valid=1 with data_out=0xDEADBEEF one cycle after the read.
- Write 0x000000A5 to IO_BASE+2 -> out_ports port 2 = 0xA5 next cycle, other ports remain 0; readback returns 0xA5.
- Drive in_ports port 1 = 0x1234 and read IO_BASE+9 -> reads returning 0x1234 require ≥2 cycles after the drive; an immediate read returns the old value.
- Write to IO_BASE+8, then read IO_BASE+12, then assert read and write together -> error bits 0, 1 and 2 set (vector 0x07). Writing 0x07 to IO_BASE+15 -> vector 0x00.
- With MEMORY_V3_BTN_LATCH_EN, pulse button 3 for 3 cycles and read IO_BASE+14 -> 0x8; a second read -> 0x0. Without the macro, a read while the button is held -> 0x8, and 0x0 after release.
